// File: rtl/io_cpx_req_if.sv
`default_nettype none
// ============================================================================
// Module   : io_cpx_req_if
// Brief    : IO-bridge enqueue and CPX request/grant signals of io_cpx_req_ctl.
// Revision : 1.0  initial release
// ============================================================================
interface io_cpx_req_if #(
  parameter int DATA_W = 145
);
  logic              iob_cpx_vld;
  logic [2:0]        iob_cpx_dest;
  logic [DATA_W-1:0] iob_cpx_data;
  logic              iob_cpx_rdy;
  logic [7:0]        io_cpx_req_cq;
  logic [DATA_W-1:0] io_cpx_data_ca;
  logic [7:0]        cpx_io_grant_ca;
  logic              io_cpx_gnt_err;

  // The controller is the source of CPX requests.
  modport master (
    input  iob_cpx_vld, iob_cpx_dest, iob_cpx_data, cpx_io_grant_ca,
    output iob_cpx_rdy, io_cpx_req_cq, io_cpx_data_ca, io_cpx_gnt_err
  );

  modport slave (
    output iob_cpx_vld, iob_cpx_dest, iob_cpx_data, cpx_io_grant_ca,
    input  iob_cpx_rdy, io_cpx_req_cq, io_cpx_data_ca, io_cpx_gnt_err
  );
endinterface
`default_nettype wire

// File: rtl/io_cpx_req_ctl.sv
`default_nettype none
// ============================================================================
// Module   : io_cpx_req_ctl
// Brief    : IO-side CPX transmit queue with per-core 2-credit request issue.
//            Optional macro IO_CPX_GNT_ERR_EN enables the sticky grant error.
// Revision : 1.0  initial release
// ============================================================================
module io_cpx_req_ctl #(
  parameter int DATA_W     = 145,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic      rclk,
  input  wire logic      arst_l,
  io_cpx_req_if.master   bus
);
  localparam int                 c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int                 c_cnt_w  = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full   = c_cnt_w'(FIFO_DEPTH);
  localparam logic [1:0]         c_oc_max = 2'd2;

  logic [2:0]         r_fifo_dest [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic               r_rdy;
  logic [7:0][1:0]    r_oc;
  logic [7:0]         w_oc_nz;
  logic [7:0]         r_req;
  logic [DATA_W-1:0]  r_data_stage;
  logic [DATA_W-1:0]  r_data_ca;
  logic               w_push;
  logic               w_pop;
  logic [2:0]         w_head_dest;
  logic [7:0]         w_inc;
  logic [7:0]         w_grant;

  assign w_grant     = bus.cpx_io_grant_ca;
  assign w_push      = bus.iob_cpx_vld & r_rdy;
  assign w_head_dest = r_fifo_dest[r_rd_ptr];
  // Issue uses the credit count from before this edge's grants.
  assign w_pop       = (r_count != '0) && (r_oc[w_head_dest] != c_oc_max);
  assign w_inc       = w_pop ? (8'h01 << w_head_dest) : 8'h00;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
      2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_oc_nz = '0;
    for (int i = 0; i < 8; i++) begin
      w_oc_nz[i] = (r_oc[i] != 2'd0);
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge rclk) begin
    if (w_push) begin
      r_fifo_dest[r_wr_ptr] <= bus.iob_cpx_dest;
      r_fifo_data[r_wr_ptr] <= bus.iob_cpx_data;
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rdy        <= 1'b0;
      r_req        <= '0;
      r_data_stage <= '0;
      r_data_ca    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + c_ptr_w'(1);
        r_data_stage <= r_fifo_data[r_rd_ptr];
      end
      r_count   <= w_count_nxt;
      r_rdy     <= (w_count_nxt != c_full);
      r_req     <= w_inc;
      r_data_ca <= (r_req != 8'h00) ? r_data_stage : '0;
    end
  end

  // Issue and grant on one core cancel; a grant with no credit out is dropped.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_oc <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_inc[i] && !w_grant[i]) begin
          r_oc[i] <= r_oc[i] + 2'd1;
        end else if (!w_inc[i] && w_grant[i] && w_oc_nz[i]) begin
          r_oc[i] <= r_oc[i] - 2'd1;
        end
      end
    end
  end

`ifdef IO_CPX_GNT_ERR_EN
  logic r_gnt_err;

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_gnt_err <= 1'b0;
    end else if ((w_grant & ~w_oc_nz) != 8'h00) begin
      r_gnt_err <= 1'b1;
    end
  end

  assign bus.io_cpx_gnt_err = r_gnt_err;
`else
  assign bus.io_cpx_gnt_err = 1'b0;
`endif

  assign bus.iob_cpx_rdy    = r_rdy;
  assign bus.io_cpx_req_cq  = r_req;
  assign bus.io_cpx_data_ca = r_data_ca;
endmodule
`default_nettype wire
